// File: rtl/fir_decim_rounder.sv
// Decimating round/saturate stage behind the systolic FIR, with a small FWFT output FIFO.
// Optional saturation counter port enabled by defining FIR_DECIM_SAT_CNT_EN.
module fir_decim_rounder #(
    parameter int unsigned IN_WIDTH    = 26,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT       = 8,
    parameter int unsigned ROUND_MODE  = 1,
    parameter int unsigned DECIM       = 4,
    parameter int unsigned DECIM_PHASE = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [IN_WIDTH-1:0]           din,
    input  logic                          sync_clr,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          sat_pulse,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = IN_WIDTH + 1;
    localparam int unsigned RW = SW - SHIFT;
    localparam int unsigned CW = (RW > OUT_WIDTH) ? RW : OUT_WIDTH;

    localparam logic [SW-1:0]        HALF    = SW'(1) << (SHIFT - 1);
    localparam logic [SW-1:0]        HALF_M1 = HALF - SW'(1);
    localparam logic signed [CW-1:0] OMAX    = {1'b0, {(CW-1){1'b1}}} >> (CW - OUT_WIDTH);
    localparam logic signed [CW-1:0] OMIN    = ~OMAX;

    logic [PW-1:0]               phase_q, phase_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [RW-1:0]        s1_data_q, s1_data_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]        s2_data_q, s2_data_d;
    logic                        s2_sat_q, s2_sat_d;
    logic                        sat_pulse_q, sat_pulse_d;
    logic                        overflow_q, overflow_d;
    logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]               level_q, level_d;
    logic                        dout_valid_q, dout_valid_d;
    logic [OUT_WIDTH-1:0]        dout_q, dout_d;
    logic [OUT_WIDTH-1:0]        mem_q [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0]        mem_d [FIFO_DEPTH];

    logic                        keep;
    logic [SW-1:0]               rnd;
    logic signed [SW-1:0]        sum;
    logic signed [CW-1:0]        s1_ext;
    logic                        push, pop, full, push_ok, drop;

    // Rounding offset selected per mode; the shift is taken as the top slice of the sum.
    always_comb begin
        rnd = '0;
        if (ROUND_MODE == 1) begin
            rnd = din[IN_WIDTH-1] ? HALF_M1 : HALF;
        end else if (ROUND_MODE == 2) begin
            rnd = HALF_M1 + SW'(din[SHIFT]);
        end
        sum = {din[IN_WIDTH-1], din} + rnd;
    end

    always_comb begin
        phase_d      = phase_q;
        s1_valid_d   = 1'b0;
        s1_data_d    = s1_data_q;
        s2_valid_d   = 1'b0;
        s2_data_d    = s2_data_q;
        s2_sat_d     = s2_sat_q;
        sat_pulse_d  = 1'b0;
        overflow_d   = overflow_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        level_d      = level_q;
        mem_d        = mem_q;
        s1_ext       = CW'(s1_data_q);

        keep    = valid_in && !sync_clr && (phase_q == PW'(DECIM_PHASE));
        pop     = dout_valid_q && dout_ready;
        push    = s2_valid_q;
        full    = (level_q == LW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;

        if (sync_clr) begin
            phase_d = '0;
        end else if (valid_in) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end

        s1_valid_d = keep;
        if (keep) begin
            s1_data_d = sum[SW-1:SHIFT];
        end

        s2_valid_d = s1_valid_q && !sync_clr;
        if (s1_valid_q) begin
            s2_sat_d = 1'b1;
            if (s1_ext > OMAX) begin
                s2_data_d = OMAX[OUT_WIDTH-1:0];
            end else if (s1_ext < OMIN) begin
                s2_data_d = OMIN[OUT_WIDTH-1:0];
            end else begin
                s2_data_d = s1_ext[OUT_WIDTH-1:0];
                s2_sat_d  = 1'b0;
            end
        end

        // Clear beats push and pop; a dropped sample still reports its saturation.
        if (sync_clr) begin
            wr_d       = '0;
            rd_d       = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            sat_pulse_d = push && s2_sat_q;
            if (push_ok) begin
                mem_d[wr_q] = s2_data_q;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            level_d    = level_q + LW'(push_ok) - LW'(pop);
            overflow_d = overflow_q || drop;
        end

        dout_valid_d = (level_d != '0);
        dout_d       = dout_valid_d ? mem_d[rd_d] : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_sat_q     <= 1'b0;
            sat_pulse_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            level_q      <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q      <= phase_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_sat_q     <= s2_sat_d;
            sat_pulse_q  <= sat_pulse_d;
            overflow_q   <= overflow_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            level_q      <= level_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign sat_pulse  = sat_pulse_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sat_count_q, sat_count_d;

    // Saturating count of clamped samples, tracking sat_pulse.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sync_clr) begin
            sat_count_d = '0;
        end else if (sat_pulse_d && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_fir_decim_rounder.sv
// Directed bench: two instances (convergent DECIM=1, half-away DECIM=4 phase 1) sharing clk/rst_n.
module tb_fir_decim_rounder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        va, ca, ra, vb, cb, rb;
    logic [25:0] da, db;
    logic        ova, spa, ofa, ovb, spb, ofb;
    logic [15:0] oda, odb;
    logic [2:0]  lva, lvb;
`ifdef FIR_DECIM_SAT_CNT_EN
    logic [15:0] sca, scb;
`endif

    int checks = 0;
    int errors = 0;

    fir_decim_rounder #(
        .IN_WIDTH(26), .OUT_WIDTH(16), .SHIFT(8), .ROUND_MODE(2),
        .DECIM(1), .DECIM_PHASE(0), .FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .valid_in(va), .din(da), .sync_clr(ca),
        .dout_valid(ova), .dout_ready(ra), .dout(oda), .sat_pulse(spa),
        .overflow(ofa), .fifo_level(lva)
`ifdef FIR_DECIM_SAT_CNT_EN
        , .sat_count(sca)
`endif
    );

    fir_decim_rounder #(
        .IN_WIDTH(26), .OUT_WIDTH(16), .SHIFT(8), .ROUND_MODE(1),
        .DECIM(4), .DECIM_PHASE(1), .FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .valid_in(vb), .din(db), .sync_clr(cb),
        .dout_valid(ovb), .dout_ready(rb), .dout(odb), .sat_pulse(spb),
        .overflow(ofb), .fifo_level(lvb)
`ifdef FIR_DECIM_SAT_CNT_EN
        , .sat_count(scb)
`endif
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int vals [4];
        int exp2 [4];
        int exp1 [4];
        int j;
        logic kept;
        vals = '{128, 384, -128, -384};
        exp2 = '{0, 2, 0, -2};
        exp1 = '{1, 2, -1, -2};

        rst_n = 1'b0;
        va = 0; ca = 0; ra = 1; da = '0;
        vb = 0; cb = 0; rb = 1; db = '0;
        repeat (2) tick();
        check("rst_a_valid", ova, 0);
        check("rst_a_dout", $signed(oda), 0);
        check("rst_a_sat", spa, 0);
        check("rst_a_ovf", ofa, 0);
        check("rst_a_level", lva, 0);
        check("rst_b_valid", ovb, 0);
        check("rst_b_level", lvb, 0);
        rst_n = 1'b1;
        tick();

        // decimation by 4, phase 1: outputs k for kept inputs 1,5,9, three negedges later
        for (int c = 0; c < 16; c++) begin
            j = c - 3;
            kept = (j >= 0) && (j < 12) && ((j % 4) == 1);
            check("decim_valid", ovb, kept);
            if (kept) check("decim_dout", $signed(odb), j);
            if (c < 12) begin vb = 1; db = 26'(256 * c); end
            else vb = 0;
            tick();
        end

        // convergent rounding
        for (int c = 0; c < 8; c++) begin
            j = c - 3;
            check("rnd2_valid", ova, (j >= 0) && (j < 4));
            if ((j >= 0) && (j < 4)) check("rnd2_dout", $signed(oda), exp2[j]);
            if (c < 4) begin va = 1; da = 26'(vals[c]); end
            else va = 0;
            tick();
        end

        // half away from zero (each value held for a full decimation period)
        for (int c = 0; c < 19; c++) begin
            j = c - 3;
            kept = (j >= 0) && (j < 16) && ((j % 4) == 1);
            if (kept) begin
                check("rnd1_valid", ovb, 1);
                check("rnd1_dout", $signed(odb), exp1[j / 4]);
            end
            if (c < 16) begin vb = 1; db = 26'(vals[c / 4]); end
            else vb = 0;
            tick();
        end

        // saturation both ways
        va = 1; da = 26'h1FFFFFF; tick();
        da = 26'h2000000; tick();
        va = 0; tick();
        check("sat_pos_dout", $signed(oda), 32767);
        check("sat_pos_pulse", spa, 1);
        tick();
        check("sat_neg_dout", $signed(oda), -32768);
        check("sat_neg_pulse", spa, 1);
        tick();
        check("sat_pulse_low", spa, 0);
`ifdef FIR_DECIM_SAT_CNT_EN
        check("sat_count", sca, 2);
`endif

        // overflow: 6 samples into a 4-deep FIFO with no consumer
        ra = 0;
        for (int i = 0; i < 6; i++) begin
            va = 1; da = 26'(256 * (i + 1)); tick();
        end
        va = 0;
        repeat (3) tick();
        check("ovf_level", lva, 4);
        check("ovf_flag", ofa, 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", ova, 1);
            check("drain_dout", $signed(oda), i + 1);
            ra = 1;
            tick();
        end
        check("drain_empty", ova, 0);
        check("drain_level", lva, 0);
        check("drain_hold", $signed(oda), 4);
        check("ovf_sticky", ofa, 1);

        // push and pop together while full
        ca = 1; tick(); ca = 0;
        check("clr_ovf", ofa, 0);
        ra = 0;
        for (int i = 0; i < 5; i++) begin
            va = 1; da = 26'(256 * (10 + i)); tick();
        end
        va = 0;
        tick();
        check("full_level", lva, 4);
        ra = 1;
        tick();
        check("pp_level", lva, 4);
        check("pp_ovf", ofa, 0);
        for (int i = 0; i < 4; i++) begin
            check("pp_dout", $signed(oda), 11 + i);
            tick();
        end
        check("pp_empty", ova, 0);

        // mid-stream sync_clr, then phase restart
        rb = 0;
        for (int c = 0; c < 22; c++) begin
            vb = 1; db = 26'(256 * c); tick();
        end
        check("pre_clr_ovf", ofb, 1);
        cb = 1; db = 26'(256 * 22); tick();
        cb = 0; vb = 0;
        check("clr_level", lvb, 0);
        check("clr_valid", ovb, 0);
        check("clr_ovf_b", ofb, 0);
        for (int c = 0; c < 8; c++) begin
            vb = 1; db = 26'(256 * (100 + c)); tick();
        end
        vb = 0;
        check("clr_restart_level", lvb, 2);
        check("clr_restart_dout", $signed(odb), 101);
        rb = 1; tick();
        check("clr_restart_dout2", $signed(odb), 105);
        tick();
        check("clr_restart_empty", ovb, 0);

        // same again with a one-cycle async reset
        rb = 0;
        for (int c = 0; c < 22; c++) begin
            vb = 1; db = 26'(256 * c); tick();
        end
        check("pre_rst_ovf", ofb, 1);
        rst_n = 0; vb = 0; tick();
        rst_n = 1;
        check("mrst_level", lvb, 0);
        check("mrst_valid", ovb, 0);
        check("mrst_ovf", ofb, 0);
        check("mrst_dout", $signed(odb), 0);
        check("mrst_sat", spb, 0);
        for (int c = 0; c < 8; c++) begin
            vb = 1; db = 26'(256 * (100 + c)); tick();
        end
        vb = 0;
        check("mrst_restart_level", lvb, 2);
        check("mrst_restart_dout", $signed(odb), 101);
        rb = 1; tick();
        check("mrst_restart_dout2", $signed(odb), 105);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
